// File: rtl/apb_slave_pkg.sv
// Shared types and address-field constants for the banked APB slave.
// Bank word index lives in Paddr[5:2]; everything above bit 5 must be zero.
package apb_slave_pkg;

  localparam int DEPTH     = 16;
  localparam int NUM_BANKS = 3;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int CNT_W     = 16;
  localparam int IDX_LSB   = 2;
  localparam int IDX_MSB   = 5;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return (addr[IDX_LSB-1:0] == '0) && (addr[ADDR_W-1:IDX_MSB+1] == '0);
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// One DEPTH x 32 storage bank: synchronous write, registered read port,
// synchronous clear of every word and of the read register.
module apb_reg_bank #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_sys,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_data;
      if (rd_en) rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/apb_slave.sv
// Banked APB slave: one bank per Pselx bit, protocol checking with a
// single-cycle proto_err pulse, saturating write/read transfer counters.
module apb_slave #(
  parameter int DEPTH     = apb_slave_pkg::DEPTH,
  parameter int NUM_BANKS = apb_slave_pkg::NUM_BANKS
) (
  input  logic                 Hclk,
  input  logic                 Hreset,
  input  logic [NUM_BANKS-1:0] Pselx,
  input  logic                 Penable,
  input  logic                 Pwrite,
  input  logic [31:0]          Paddr,
  input  logic [31:0]          Pwdata,
  output logic [31:0]          Prdata,
  output logic                 proto_err,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count
);
  import apb_slave_pkg::*;

  // state  | meaning
  // IDLE   | no transfer in flight
  // SETUP  | setup phase captured; this cycle must be the matching access phase
  // ACCESS | access phase just completed; a new setup may follow immediately
  localparam int AW = $clog2(DEPTH);

  apb_state_t state_q, state_d;

  logic [NUM_BANKS-1:0] cap_sel_q;
  logic [ADDR_W-1:0]    cap_addr_q;
  logic                 cap_write_q;
  logic                 cap_bad_q;
  logic [NUM_BANKS-1:0] rd_src_q;
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

  logic sel, bad_now, match, start, commit, err_d;

  assign sel     = |Pselx;
  assign bad_now = !$onehot(Pselx) || !addr_ok(Paddr);
  assign match   = Penable && (Pselx == cap_sel_q) && (Paddr == cap_addr_q)
                   && (Pwrite == cap_write_q);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel && Penable) err_d = 1'b1;
        else if (sel) start = 1'b1;
      end
      SETUP: begin
        if (match) begin
          state_d = ACCESS;
          if (cap_bad_q) err_d = 1'b1;
          else commit = 1'b1;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (sel && Penable) err_d = 1'b1;
        else if (sel) start = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (start) state_d = SETUP;
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q     <= IDLE;
      cap_sel_q   <= '0;
      cap_addr_q  <= '0;
      cap_write_q <= 1'b0;
      cap_bad_q   <= 1'b0;
      rd_src_q    <= '0;
      proto_err   <= 1'b0;
      wr_count    <= '0;
      rd_count    <= '0;
    end else begin
      state_q   <= state_d;
      proto_err <= err_d;
      if (start) begin
        cap_sel_q   <= Pselx;
        cap_addr_q  <= Paddr;
        cap_write_q <= Pwrite;
        cap_bad_q   <= bad_now;
        // A bad read selects no bank, so Prdata reads back as zero
        if (!Pwrite) rd_src_q <= bad_now ? '0 : Pselx;
      end
      if (commit) begin
        if (cap_write_q) begin
          if (wr_count != '1) wr_count <= wr_count + 1'b1;
        end else begin
          if (rd_count != '1) rd_count <= rd_count + 1'b1;
        end
      end
    end
  end

  for (genvar n = 0; n < NUM_BANKS; n++) begin : g_bank
    apb_reg_bank #(.DEPTH(DEPTH)) u_bank (
      .clk_sys (Hclk),
      .clr     (Hreset),
      .wr_en   (commit && cap_write_q && cap_sel_q[n]),
      .wr_idx  (cap_addr_q[IDX_LSB +: AW]),
      .wr_data (Pwdata),
      .rd_en   (start && !Pwrite && !bad_now && Pselx[n]),
      .rd_idx  (Paddr[IDX_LSB +: AW]),
      .rd_data (bank_rdata[n])
    );
  end

  always_comb begin
    Prdata = '0;
    for (int n = 0; n < NUM_BANKS; n++) begin
      if (rd_src_q[n]) Prdata = Prdata | bank_rdata[n];
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// Scoreboard bench for apb_slave: a transfer-level model queues the expected
// outputs per clock; a separate monitor pops and compares on the falling edge.
module tb_apb_slave;

  logic        Hclk = 1'b0;
  logic        Hreset, Penable, Pwrite;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata, Prdata;
  logic        proto_err;
  logic [15:0] wr_count, rd_count;

  apb_slave dut (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata),
    .proto_err(proto_err), .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 Hclk = ~Hclk;

  int unsigned cyc = 0;
  always @(posedge Hclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [15:0] wc;
    logic [15:0] rc;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] m_mem [3][16];
  int          m_wc, m_rc;
  logic [31:0] m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, ex);
    end
  endtask

  always @(negedge Hclk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stale_expect: item for cyc %0d seen at cyc %0d", e.cyc, cyc);
      end else begin
        chk("proto_err", {31'b0, proto_err}, {31'b0, e.err});
        chk("wr_count", {16'b0, wr_count}, {16'b0, e.wc});
        chk("rd_count", {16'b0, rd_count}, {16'b0, e.rc});
        chk("Prdata", Prdata, e.rd);
      end
    end
  end

  task automatic model_reset();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 16; i++) m_mem[b][i] = '0;
    m_wc = 0;
    m_rc = 0;
    m_rd = '0;
  endtask

  // Drive one clock worth of bus inputs; the expectation is what the
  // outputs must show after the edge that samples them.
  task automatic step(input logic [2:0] s, input logic en, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic rst, input logic err);
    exp_t e;
    Hreset = rst; Pselx = s; Penable = en; Pwrite = w; Paddr = a; Pwdata = d;
    e.cyc = cyc + 1;
    e.err = err;
    e.wc  = 16'(m_wc);
    e.rc  = 16'(m_rc);
    e.rd  = m_rd;
    exp_q.push_back(e);
    @(posedge Hclk);
    #1;
  endtask

  // viol: 0 = clean transfer, 1 = address changes in access phase,
  //       2 = reset asserted during access phase
  task automatic xfer(input logic [2:0] s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int viol);
    bit bad;
    int b;
    logic [3:0] idx;
    bad = ($countones(s) != 1) || (a[1:0] != 2'b00) || (a[31:6] != 26'b0);
    b   = $clog2(s);
    idx = a[5:2];
    if (!w) m_rd = bad ? 32'h0 : m_mem[b][idx];
    step(s, 1'b0, w, a, d, 1'b0, 1'b0);
    case (viol)
      1: step(s, 1'b1, w, a ^ 32'hC, d, 1'b0, 1'b1);
      2: begin
        model_reset();
        step(s, 1'b1, w, a, d, 1'b1, 1'b0);
      end
      default: begin
        if (!bad) begin
          if (w) begin
            m_mem[b][idx] = d;
            if (m_wc < 65535) m_wc++;
          end else if (m_rc < 65535) m_rc++;
        end
        step(s, 1'b1, w, a, d, 1'b0, bad);
      end
    endcase
  endtask

  task automatic idle();
    step(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic stray(input logic [2:0] s, input logic [31:0] a);
    step(s, 1'b1, 1'b0, a, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0]  s;
    logic [31:0] a;
    logic        w;
    int          r, k;

    model_reset();
    step(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    xfer(3'b001, 1'b1, 32'h08, 32'hDEADBEEF, 0);
    xfer(3'b001, 1'b0, 32'h08, 32'h0, 0);
    xfer(3'b100, 1'b1, 32'h3C, 32'h12345678, 0);
    xfer(3'b010, 1'b0, 32'h3C, 32'h0, 0);
    xfer(3'b100, 1'b0, 32'h3C, 32'h0, 0);
    xfer(3'b001, 1'b0, 32'h06, 32'h0, 0);
    idle();
    stray(3'b001, 32'h0);
    idle();
    xfer(3'b001, 1'b1, 32'h04, 32'hAAAA5555, 1);
    xfer(3'b001, 1'b0, 32'h04, 32'h0, 0);
    xfer(3'b001, 1'b0, 32'h08, 32'h0, 0);
    xfer(3'b001, 1'b1, 32'h00, 32'hCAFEF00D, 2);
    idle();
    xfer(3'b001, 1'b0, 32'h00, 32'h0, 0);
    xfer(3'b001, 1'b0, 32'h08, 32'h0, 0);
    xfer(3'b011, 1'b1, 32'h10, 32'h11112222, 0);
    xfer(3'b010, 1'b0, 32'h10, 32'h0, 0);
    xfer(3'b010, 1'b1, 32'h40, 32'h33334444, 0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      s = 3'b001 << $urandom_range(0, 2);
      if (r < 8) begin
        s = 3'($urandom_range(3, 7));
        if (s == 3'b100) s = 3'b111;
      end
      a = {26'b0, 4'($urandom_range(0, (r & 1) ? 3 : 15)), 2'b00};
      if (r >= 8 && r < 14) a[1:0] = 2'($urandom_range(1, 3));
      if (r >= 14 && r < 18) a[$urandom_range(6, 31)] = 1'b1;
      w = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 99);
      if (k < 80) xfer(s, w, a, $urandom, 0);
      else if (k < 87) xfer(s, w, a, $urandom, 1);
      else if (k < 90) xfer(s, w, a, $urandom, 2);
      else if (k < 95) stray(s, a);
      else idle();
      if ($urandom_range(0, 3) == 0) idle();
    end

    idle();
    idle();
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge Hclk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameter: DEPTH, 16, 32-bit words per bank; word index = Paddr[5:2].
REQ-002 Parameter: NUM_BANKS, 3, one bank per Pselx bit.
REQ-003 Port: Hclk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: Hreset  input  1  reset, synchronous, active-high.
REQ-005 Port: Pselx  input  3  one-hot slave select; bit n selects bank n.
REQ-006 Port: Penable  input  1  APB access-phase strobe.
REQ-007 Port: Pwrite  input  1  1 = write, 0 = read.
REQ-008 Port: Paddr  input  32  byte address.
REQ-009 Port: Pwdata  input  32  write data.
REQ-010 Port: Prdata  output  32  registered read data.
REQ-011 Port: proto_err  output  1  one-cycle pulse on APB protocol violation or bad access.
REQ-012 Port: wr_count  output  16  committed writes, saturating at 16'hFFFF.
REQ-013 Port: rd_count  output  16  completed reads, saturating at 16'hFFFF.

Function
REQ-014 FSM states IDLE, SETUP, ACCESS; "sel" = Pselx != 0.
REQ-015 IDLE: sel & !Penable -> SETUP; sel & Penable -> proto_err, stay IDLE; !sel -> stay IDLE.
REQ-016 SETUP -> ACCESS only if Penable=1 and Pselx, Paddr, Pwrite equal the values captured at setup; otherwise proto_err and go to IDLE, no access performed.
REQ-017 ACCESS: sel & !Penable -> SETUP (back-to-back, zero idle); !sel -> IDLE; sel & Penable -> proto_err, IDLE.
REQ-018 Setup phase captures Pselx, Paddr, Pwrite into internal registers on the rising edge that ends it.
REQ-019 Read: on edge ending a valid read setup, Prdata loads bank[Pselx][Paddr[5:2]]; Prdata is stable for the whole access cycle (latency one cycle from setup).
REQ-020 Prdata holds its last value in all other cycles.
REQ-021 Write: bank[sel][idx] <= Pwdata on the edge ending a valid write access phase; no earlier visibility.
REQ-022 Bad access = Pselx not one-hot, or Paddr[1:0] != 0, or Paddr[31:6] != 0; detected at setup.
REQ-023 Bad access: setup/access sequence proceeds normally, write is dropped, read loads Prdata = 32'h0, proto_err pulses on edge ending access phase, counters unchanged.
REQ-024 wr_count/rd_count increment by 1 on edge ending a valid, good access; hold at 16'hFFFF.
REQ-025 proto_err is registered, high exactly one cycle per violation; simultaneous violations produce one pulse.
REQ-026 Read-after-write to same word in back-to-back transfers returns new data (write commits before next setup edge).

Reset
REQ-027 Hreset=1 sampled at rising edge: FSM -> IDLE, Prdata = 0, proto_err = 0, wr_count = rd_count = 0, all bank words = 0, captured registers = 0.
REQ-028 Reset mid-transfer aborts it: in-flight write not committed, no counter change, no proto_err.
REQ-029 Hreset has priority over every other input in the same cycle.

Structure
REQ-030 Package apb_slave_pkg holds state enum (IDLE, SETUP, ACCESS), DEPTH, NUM_BANKS, address-field constants.
REQ-031 Sub-module apb_reg_bank: one DEPTH x 32 bank with sync write, registered read, sync clear; apb_slave instantiates NUM_BANKS copies.

Verification
REQ-032 Reset, then write Pselx=3'b001 Paddr=32'h08 Pwdata=32'hDEADBEEF -> bank0[2]=DEADBEEF, wr_count=1, proto_err=0.
REQ-033 Read same address, next transfer back-to-back -> Prdata=32'hDEADBEEF throughout access cycle, rd_count=1.
REQ-034 Write Pselx=3'b100 Paddr=32'h3C Pwdata=32'h12345678, read Pselx=3'b010 Paddr=32'h3C -> Prdata=0 (banks independent).
REQ-035 Read Paddr=32'h06 (misaligned) -> Prdata=0, one proto_err pulse, rd_count unchanged.
REQ-036 Penable=1 with Pselx=3'b001 from IDLE; separately Paddr changed 04->08 between setup and access -> proto_err pulse each, no memory change.
REQ-037 Hreset asserted during access phase of write 32'hCAFEF00D to 32'h00 -> bank0[0]=0, wr_count=0, FSM IDLE next cycle.
